fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-003 SHALL have port stall, input, 1 bit, from hazard unit; holds the PC and F/D registers.
REQ-004 SHALL have port cmp_out, input, 1 bit, branch condition from the D-stage comparator (1 = taken).
REQ-005 SHALL have port npc_op, input, 3 bits, D-stage next-PC select: 000 seq, 001 branch, 010 jump (j/jal), 011 jump-register (jr).
REQ-006 SHALL have port d_imm16, input, 16 bits, D-instruction offset field.
REQ-007 SHALL have port d_imm26, input, 26 bits, D-instruction index field.
REQ-008 SHALL have port d_rs_val, input, 32 bits, forwarded rs value for jr.
REQ-009 SHALL have port im_instr, input, 32 bits, instruction word returned combinationally by instruction memory for im_addr.
REQ-010 SHALL have port im_addr, output, 32 bits, current fetch PC (F_PC).
REQ-011 SHALL have port d_instr, output, 32 bits, F/D register instruction.
REQ-012 SHALL have port d_pc, output, 32 bits, F/D register PC.
REQ-013 SHALL have port d_pc8, output, 32 bits, d_pc + 8, the link value for jal.

Function
REQ-014 SHALL hold F_PC in a 32-bit register; im_addr = F_PC combinationally.
REQ-015 SHALL compute NPC combinationally: seq = F_PC + 4.
REQ-016 SHALL compute branch target = d_pc + 4 + (sign-extended d_imm16 << 2); with npc_op=001, NPC = target if cmp_out=1, else F_PC + 4.
REQ-017 SHALL compute jump target = {d_pc[31:28], d_imm26, 2'b00} when npc_op=010.
REQ-018 SHALL set NPC = d_rs_val unmodified (no alignment masking) when npc_op=011.
REQ-019 SHALL treat npc_op values 100-111 as seq (F_PC + 4).
REQ-020 SHALL perform all address arithmetic modulo 2^32; 0xFFFFFFFC + 4 = 0x00000000, with no error flag.
REQ-021 SHALL implement delayed branching: the instruction already fetched when a branch or jump is in D (the delay slot) always enters D; the F/D register is never flushed.
REQ-022 SHALL, each non-stalled, non-reset cycle, load F_PC <= NPC, d_instr <= im_instr, d_pc <= F_PC.
REQ-023 SHALL, when stall=1 and reset=0, hold F_PC, d_instr and d_pc unchanged; NPC SHALL be re-evaluated the next cycle from the held D contents.
REQ-024 SHALL give reset priority over stall.
REQ-025 SHALL make d_pc8 purely combinational from d_pc; no extra latency.
REQ-026 SHALL have one-cycle latency from im_instr to d_instr.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set F_PC = 0x00003000, d_instr = 0x00000000 (nop), and d_pc = 0x00000000.
REQ-028 SHALL, when reset is asserted mid-operation, discard any pending branch or jump; the first post-reset fetch is 0x00003000.

Structure
REQ-029 SHALL take the npc_op encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR) and RESET_PC = 0x00003000 from the shared CPU constants package, which the controller also uses.
REQ-030 SHALL place the combinational next-PC selection in one sub-module named npc; the PC and F/D registers live in fetch_stage.

Verification
REQ-031 Test SHALL check reset: after reset, im_addr = 0x00003000 and d_instr = 0; 3 free cycles then give im_addr = 0x0000300C and d_pc = 0x00003008.
REQ-032 Test SHALL check a taken branch: d_pc = 0x00003004, npc_op=001, d_imm16=0xFFFF, cmp_out=1 -> next im_addr = 0x00003004 (d_pc + 4 - 4); the delay-slot instruction at F_PC enters D.
REQ-033 Test SHALL check a not-taken branch: same stimulus with cmp_out=0 -> next im_addr = F_PC + 4.
REQ-034 Test SHALL check jump and jr: npc_op=010, d_pc = 0x00003010, d_imm26 = 0x0000C10 -> NPC = 0x00003040; npc_op=011, d_rs_val = 0x00003100 -> NPC = 0x00003100.
REQ-035 Test SHALL check stall: stall=1 for 2 cycles with a branch in D -> im_addr, d_instr and d_pc frozen; the branch resolves correctly on the first non-stalled edge.
REQ-036 Test SHALL check priority and wrap: reset=1 together with stall=1 -> reset values loaded; F_PC forced to 0xFFFFFFFC then seq -> 0x00000000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU constants: next-PC select encodings driven by the D-stage
// controller and the PC value loaded on reset. Imported by the controller,
// fetch_stage and npc so all of them agree on the encodings.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'b000,
    NPC_BR  = 3'b001,
    NPC_J   = 3'b010,
    NPC_JR  = 3'b011
  } npc_op_e;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0]       NOP_INSTR = 32'h0000_0000;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_npc.sv
// -----------------------------------------------------------------------------
// npc
// Combinational next-PC selection for the fetch stage.
//   f_pc_i    : current fetch PC
//   d_pc_i    : PC of the instruction in D (branch/jump base)
//   cmp_out_i : branch condition from D comparator, 1 = taken
//   npc_op_i  : next-PC select (seq / branch / jump / jump-register)
//   d_imm16_i : branch offset field
//   d_imm26_i : jump index field
//   d_rs_val_i: forwarded rs value for jr
//   npc_o     : next fetch PC
// All arithmetic wraps modulo 2^32.
// -----------------------------------------------------------------------------
module npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic        cmp_out_i,
  input  logic [2:0]  npc_op_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_imm26_i,
  input  logic [31:0] d_rs_val_i,
  output logic [31:0] npc_o
);

  logic        [31:0] seq_pc;
  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  assign seq_pc    = f_pc_i + 32'd4;
  // Sign-extend the 16-bit word offset, then scale to bytes.
  assign br_off    = {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
  assign br_target = d_pc_i + 32'd4 + $unsigned(br_off);
  assign j_target  = {d_pc_i[31:28], d_imm26_i, 2'b00};

  always_comb begin
    npc_o = seq_pc;
    case (npc_op_i)
      NPC_BR:  npc_o = cmp_out_i ? br_target : seq_pc;
      NPC_J:   npc_o = j_target;
      // jr target is taken as-is; misaligned addresses are not masked.
      NPC_JR:  npc_o = d_rs_val_i;
      default: npc_o = seq_pc;
    endcase
  end

endmodule : npc

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with delayed branching: holds the fetch PC and the F/D
// pipeline register. The instruction in the delay slot always advances to D;
// the F/D register is never flushed.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; has priority over stall
//   stall    : hold PC and F/D registers
//   cmp_out  : D-stage branch condition (1 = taken)
//   npc_op   : D-stage next-PC select
//   d_imm16  : D-instruction offset field
//   d_imm26  : D-instruction index field
//   d_rs_val : forwarded rs value for jr
//   im_instr : instruction word for im_addr (combinational memory)
//   im_addr  : current fetch PC
//   d_instr  : F/D instruction
//   d_pc     : F/D PC
//   d_pc8    : d_pc + 8, jal link value
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cmp_out,
  input  logic [2:0]  npc_op,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] im_instr,
  output logic [31:0] im_addr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8
);

  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic [31:0] npc_val;

  npc u_npc (
    .f_pc_i    (f_pc_q),
    .d_pc_i    (d_pc_q),
    .cmp_out_i (cmp_out),
    .npc_op_i  (npc_op),
    .d_imm16_i (d_imm16),
    .d_imm26_i (d_imm26),
    .d_rs_val_i(d_rs_val),
    .npc_o     (npc_val)
  );

  // Stall simply recirculates; npc is re-evaluated from the held D contents.
  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (!stall) begin
      f_pc_d    = npc_val;
      d_instr_d = im_instr;
      d_pc_d    = f_pc_q;
    end
  end

  // F -> D boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= NOP_INSTR;
      d_pc_q    <= 32'h0000_0000;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
    end
  end

  assign im_addr = f_pc_q;
  assign d_instr = d_instr_q;
  assign d_pc    = d_pc_q;
  assign d_pc8   = d_pc_q + 32'd8;

endmodule : fetch_stage
